timer_bus_if: RTL and testbench

//   Byte-wide CPU write front end for TIMER. Accepts 8-bit CPU bus writes,

---
 rtl/timer_bus_if.sv | 168 ++++++++++++++++
 tb/tb_timer_bus_if.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/timer_bus_if.sv
// -----------------------------------------------------------------------------
// timer_bus_if
//
// Byte-wide CPU write front end for the TIMER block. CPU writes are
// edge-detected on the (cpu_cs & cpu_wr) level strobe, so a strobe held for
// many cycles produces only one accept. Control words (cpu_a0=1) are always
// forwarded. Their RW field selects how later count bytes are assembled into
// 16-bit TIMER writes: LSB only, MSB only, or an LSB/MSB pair. Every TIMER
// transaction is a registered single-cycle t_cs/t_wr pulse that appears one
// cycle after the accept.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   cpu_data  in   CPU write data (BUS_W)
//   cpu_cs    in   CPU chip select, active high
//   cpu_wr    in   CPU write strobe, active high level
//   cpu_a0    in   1 = control word, 0 = count byte
//   t_data    out  data to TIMER (CNT_W), holds last issued value
//   t_cs      out  chip select to TIMER (one-cycle pulse)
//   t_wr      out  write strobe to TIMER (one-cycle pulse)
//   t_a0      out  register select to TIMER, holds last issued value
//   rw_mode   out  RW field of the last accepted non-latch control word
//   lsb_pend  out  LSB of an LSB/MSB pair is held, waiting for its MSB
//   err       out  one-cycle pulse: count byte written with no RW mode set
// -----------------------------------------------------------------------------
module timer_bus_if #(
    parameter int BUS_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BUS_W-1:0] cpu_data,
    input  logic             cpu_cs,
    input  logic             cpu_wr,
    input  logic             cpu_a0,
    output logic [CNT_W-1:0] t_data,
    output logic             t_cs,
    output logic             t_wr,
    output logic             t_a0,
    output logic [1:0]       rw_mode,
    output logic             lsb_pend,
    output logic             err
);

    typedef enum logic [2:0] {
        NO_MODE  = 3'd0,
        LSB_ONLY = 3'd1,
        MSB_ONLY = 3'd2,
        PAIR_LSB = 3'd3,
        PAIR_MSB = 3'd4
    } state_t;

    state_t             state_q,    state_d;
    logic               wr_q,       wr_d;
    logic               txn_q,      txn_d;
    logic [CNT_W-1:0]   t_data_q,   t_data_d;
    logic               t_a0_q,     t_a0_d;
    logic [1:0]         rw_mode_q,  rw_mode_d;
    logic               lsb_pend_q, lsb_pend_d;
    logic               err_q,      err_d;
    logic [BUS_W-1:0]   lsb_hold_q, lsb_hold_d;

    logic               accept;
    logic [1:0]         rw_field;

    // Rising edge of the combined strobe. Because wr_q tracks the combined
    // strobe (not cpu_wr alone), raising cs under an already-held wr counts.
    assign accept   = cpu_cs & cpu_wr & ~wr_q;
    assign rw_field = cpu_data[5:4];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= NO_MODE;
            wr_q       <= 1'b0;
            txn_q      <= 1'b0;
            t_data_q   <= '0;
            t_a0_q     <= 1'b0;
            rw_mode_q  <= 2'b00;
            lsb_pend_q <= 1'b0;
            err_q      <= 1'b0;
            lsb_hold_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            txn_q      <= txn_d;
            t_data_q   <= t_data_d;
            t_a0_q     <= t_a0_d;
            rw_mode_q  <= rw_mode_d;
            lsb_pend_q <= lsb_pend_d;
            err_q      <= err_d;
            lsb_hold_q <= lsb_hold_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_d       = cpu_cs & cpu_wr;
        txn_d      = 1'b0;
        t_data_d   = t_data_q;
        t_a0_d     = t_a0_q;
        rw_mode_d  = rw_mode_q;
        lsb_pend_d = lsb_pend_q;
        err_d      = 1'b0;
        lsb_hold_d = lsb_hold_q;

        if (accept) begin
            if (cpu_a0) begin
                // Control words always reach TIMER, including latch commands.
                txn_d    = 1'b1;
                t_a0_d   = 1'b1;
                t_data_d = {{(CNT_W-BUS_W){1'b0}}, cpu_data};
                // RW=00 is a latch command: it leaves the byte sequencing
                // untouched. Any other RW restarts sequencing and drops a
                // half-written pair.
                if (rw_field != 2'b00) begin
                    rw_mode_d  = rw_field;
                    lsb_pend_d = 1'b0;
                    unique case (rw_field)
                        2'b01:   state_d = LSB_ONLY;
                        2'b10:   state_d = MSB_ONLY;
                        default: state_d = PAIR_LSB;
                    endcase
                end
            end else begin
                case (state_q)
                    NO_MODE: begin
                        err_d = 1'b1;
                    end
                    LSB_ONLY: begin
                        txn_d    = 1'b1;
                        t_a0_d   = 1'b0;
                        t_data_d = {{(CNT_W-BUS_W){1'b0}}, cpu_data};
                    end
                    MSB_ONLY: begin
                        txn_d    = 1'b1;
                        t_a0_d   = 1'b0;
                        t_data_d = {cpu_data, {BUS_W{1'b0}}};
                    end
                    PAIR_LSB: begin
                        lsb_hold_d = cpu_data;
                        lsb_pend_d = 1'b1;
                        state_d    = PAIR_MSB;
                    end
                    PAIR_MSB: begin
                        txn_d      = 1'b1;
                        t_a0_d     = 1'b0;
                        t_data_d   = {cpu_data, lsb_hold_q};
                        lsb_pend_d = 1'b0;
                        state_d    = PAIR_LSB;
                    end
                    default: begin
                        state_d = NO_MODE;
                    end
                endcase
            end
        end
    end

    assign t_data   = t_data_q;
    assign t_cs     = txn_q;
    assign t_wr     = txn_q;
    assign t_a0     = t_a0_q;
    assign rw_mode  = rw_mode_q;
    assign lsb_pend = lsb_pend_q;
    assign err      = err_q;

endmodule

// File: tb/tb_timer_bus_if.sv
module tb_timer_bus_if;

    logic        clk;
    logic        reset;
    logic [7:0]  cpu_data;
    logic        cpu_cs;
    logic        cpu_wr;
    logic        cpu_a0;
    logic [15:0] t_data;
    logic        t_cs;
    logic        t_wr;
    logic        t_a0;
    logic [1:0]  rw_mode;
    logic        lsb_pend;
    logic        err;

    int checks = 0;
    int errors = 0;

    timer_bus_if #(.BUS_W(8), .CNT_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_data (cpu_data),
        .cpu_cs   (cpu_cs),
        .cpu_wr   (cpu_wr),
        .cpu_a0   (cpu_a0),
        .t_data   (t_data),
        .t_cs     (t_cs),
        .t_wr     (t_wr),
        .t_a0     (t_a0),
        .rw_mode  (rw_mode),
        .lsb_pend (lsb_pend),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One idle cycle (clears the strobe history), then a one-cycle strobe.
    // On return the outputs show the result of that accept.
    task automatic cpu_write(input logic a0, input logic [7:0] data);
        step();
        cpu_cs   = 1'b1;
        cpu_wr   = 1'b1;
        cpu_a0   = a0;
        cpu_data = data;
        step();
        cpu_cs = 1'b0;
        cpu_wr = 1'b0;
        $display("write a0=%0b data=%02h -> t_wr=%0b t_cs=%0b t_a0=%0b t_data=%04h rw=%0d pend=%0b err=%0b",
                 a0, data, t_wr, t_cs, t_a0, t_data, rw_mode, lsb_pend, err);
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_cs = 1'b0; cpu_wr = 1'b0; cpu_a0 = 1'b0; cpu_data = 8'h00;
        step(); step(); step();
        reset = 1'b0;
        step();
        checks++; if (t_wr !== 1'b0 || t_cs !== 1'b0) begin errors++; $display("FAIL reset_strobe: got wr=%0b cs=%0b want 0 0", t_wr, t_cs); end
        checks++; if (t_data !== 16'h0000 || t_a0 !== 1'b0) begin errors++; $display("FAIL reset_data: got %04h a0=%0b want 0000 0", t_data, t_a0); end
        checks++; if (rw_mode !== 2'b00 || lsb_pend !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_status: got rw=%0d pend=%0b err=%0b want 0 0 0", rw_mode, lsb_pend, err); end
    endtask

    task automatic test_no_mode_err();
        cpu_write(1'b0, 8'h55);
        checks++; if (t_wr !== 1'b0 || t_cs !== 1'b0) begin errors++; $display("FAIL nomode_no_txn: got wr=%0b cs=%0b want 0 0", t_wr, t_cs); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL nomode_err: got %0b want 1", err); end
        step();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL nomode_err_pulse: got %0b want 0", err); end
        // Still in NO_MODE: another count byte errors again.
        cpu_write(1'b0, 8'h66);
        checks++; if (err !== 1'b1 || t_wr !== 1'b0 || t_data !== 16'h0000) begin errors++; $display("FAIL nomode_stays: got err=%0b wr=%0b data=%04h want 1 0 0000", err, t_wr, t_data); end
    endtask

    task automatic test_pair();
        cpu_write(1'b1, 8'h30);
        checks++; if (t_wr !== 1'b1 || t_cs !== 1'b1 || t_a0 !== 1'b1) begin errors++; $display("FAIL pair_ctrl_txn: got wr=%0b cs=%0b a0=%0b want 1 1 1", t_wr, t_cs, t_a0); end
        checks++; if (t_data !== 16'h0030 || rw_mode !== 2'b11) begin errors++; $display("FAIL pair_ctrl_data: got %04h rw=%0d want 0030 3", t_data, rw_mode); end
        cpu_write(1'b0, 8'h34);
        checks++; if (t_wr !== 1'b0 || lsb_pend !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL pair_lsb: got wr=%0b pend=%0b err=%0b want 0 1 0", t_wr, lsb_pend, err); end
        checks++; if (t_data !== 16'h0030) begin errors++; $display("FAIL pair_lsb_hold_data: got %04h want 0030", t_data); end
        cpu_write(1'b0, 8'h12);
        checks++; if (t_wr !== 1'b1 || t_a0 !== 1'b0 || t_data !== 16'h1234) begin errors++; $display("FAIL pair_msb: got wr=%0b a0=%0b data=%04h want 1 0 1234", t_wr, t_a0, t_data); end
        checks++; if (lsb_pend !== 1'b0) begin errors++; $display("FAIL pair_msb_pend: got %0b want 0", lsb_pend); end
        // Back in PAIR_LSB: next pair assembles again.
        cpu_write(1'b0, 8'hEF);
        cpu_write(1'b0, 8'hBE);
        checks++; if (t_wr !== 1'b1 || t_data !== 16'hBEEF) begin errors++; $display("FAIL pair_second: got wr=%0b data=%04h want 1 BEEF", t_wr, t_data); end
    endtask

    task automatic test_lsb_msb_only();
        cpu_write(1'b1, 8'h10);
        checks++; if (rw_mode !== 2'b01 || t_data !== 16'h0010 || t_a0 !== 1'b1) begin errors++; $display("FAIL lsb_ctrl: got rw=%0d data=%04h a0=%0b want 1 0010 1", rw_mode, t_data, t_a0); end
        cpu_write(1'b0, 8'hAB);
        checks++; if (t_wr !== 1'b1 || t_a0 !== 1'b0 || t_data !== 16'h00AB) begin errors++; $display("FAIL lsb_only: got wr=%0b a0=%0b data=%04h want 1 0 00AB", t_wr, t_a0, t_data); end
        cpu_write(1'b1, 8'h20);
        checks++; if (rw_mode !== 2'b10) begin errors++; $display("FAIL msb_ctrl: got rw=%0d want 2", rw_mode); end
        cpu_write(1'b0, 8'hCD);
        checks++; if (t_wr !== 1'b1 || t_data !== 16'hCD00) begin errors++; $display("FAIL msb_only: got wr=%0b data=%04h want 1 CD00", t_wr, t_data); end
        // Latch command: forwarded, mode unchanged.
        cpu_write(1'b1, 8'hC0);
        checks++; if (t_wr !== 1'b1 || t_data !== 16'h00C0 || rw_mode !== 2'b10) begin errors++; $display("FAIL latch_cmd: got wr=%0b data=%04h rw=%0d want 1 00C0 2", t_wr, t_data, rw_mode); end
        cpu_write(1'b0, 8'h77);
        checks++; if (t_wr !== 1'b1 || t_data !== 16'h7700) begin errors++; $display("FAIL latch_keeps_mode: got wr=%0b data=%04h want 1 7700", t_wr, t_data); end
    endtask

    task automatic test_held_strobe();
        int pulses;
        pulses = 0;
        step();
        cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_a0 = 1'b1; cpu_data = 8'h30;
        for (int i = 0; i < 10; i++) begin
            step();
            if (t_wr === 1'b1) pulses++;
            if (i == 0) begin
                checks++; if (t_wr !== 1'b1 || t_cs !== 1'b1) begin errors++; $display("FAIL held_first: got wr=%0b cs=%0b want 1 1", t_wr, t_cs); end
            end
        end
        checks++; if (t_cs !== 1'b0 || t_wr !== 1'b0) begin errors++; $display("FAIL held_low: got wr=%0b cs=%0b want 0 0", t_wr, t_cs); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL held_pulses: got %0d want 1", pulses); end
        checks++; if (t_data !== 16'h0030 || t_a0 !== 1'b1) begin errors++; $display("FAIL held_data_hold: got %04h a0=%0b want 0030 1", t_data, t_a0); end
        cpu_cs = 1'b0; cpu_wr = 1'b0;
        $display("held write a0=1 data=30 for 10 cycles -> pulses=%0d", pulses);
    endtask

    task automatic test_abort_pair();
        cpu_write(1'b1, 8'h30);
        cpu_write(1'b0, 8'h11);
        checks++; if (lsb_pend !== 1'b1 || t_wr !== 1'b0) begin errors++; $display("FAIL abort_lsb: got pend=%0b wr=%0b want 1 0", lsb_pend, t_wr); end
        cpu_write(1'b1, 8'h30);
        checks++; if (lsb_pend !== 1'b0 || t_data !== 16'h0030 || t_wr !== 1'b1) begin errors++; $display("FAIL abort_ctrl: got pend=%0b data=%04h wr=%0b want 0 0030 1", lsb_pend, t_data, t_wr); end
        cpu_write(1'b0, 8'h22);
        checks++; if (t_wr !== 1'b0 || lsb_pend !== 1'b1) begin errors++; $display("FAIL abort_new_lsb: got wr=%0b pend=%0b want 0 1", t_wr, lsb_pend); end
        cpu_write(1'b0, 8'h33);
        checks++; if (t_wr !== 1'b1 || t_data !== 16'h3322) begin errors++; $display("FAIL abort_pair: got wr=%0b data=%04h want 1 3322", t_wr, t_data); end
    endtask

    task automatic test_cs_edge();
        int pulses;
        pulses = 0;
        step();
        cpu_cs = 1'b0; cpu_wr = 1'b1; cpu_a0 = 1'b1; cpu_data = 8'h20;
        for (int i = 0; i < 3; i++) begin
            step();
            if (t_wr === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL cs_low_no_accept: got %0d pulses want 0", pulses); end
        cpu_cs = 1'b1;
        step();
        checks++; if (t_wr !== 1'b1 || rw_mode !== 2'b10 || t_data !== 16'h0020) begin errors++; $display("FAIL cs_rise_accept: got wr=%0b rw=%0d data=%04h want 1 2 0020", t_wr, rw_mode, t_data); end
        cpu_cs = 1'b0; cpu_wr = 1'b0;
        $display("cs edge under held wr a0=1 data=20 -> t_wr=%0b", t_wr);
    endtask

    task automatic test_reset_mid();
        cpu_write(1'b1, 8'h30);
        cpu_write(1'b0, 8'h11);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (rw_mode !== 2'b00 || lsb_pend !== 1'b0 || t_data !== 16'h0000) begin errors++; $display("FAIL rstmid_clear: got rw=%0d pend=%0b data=%04h want 0 0 0000", rw_mode, lsb_pend, t_data); end
        cpu_write(1'b0, 8'h22);
        checks++; if (err !== 1'b1 || t_wr !== 1'b0 || t_data !== 16'h0000) begin errors++; $display("FAIL rstmid_count: got err=%0b wr=%0b data=%04h want 1 0 0000", err, t_wr, t_data); end
    endtask

    task automatic test_reset_on_issue();
        cpu_write(1'b1, 8'h20);
        step();
        cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_a0 = 1'b1; cpu_data = 8'h10;
        reset = 1'b1;
        step();
        reset = 1'b0; cpu_cs = 1'b0; cpu_wr = 1'b0;
        checks++; if (t_wr !== 1'b0 || t_cs !== 1'b0 || rw_mode !== 2'b00 || t_data !== 16'h0000) begin errors++; $display("FAIL rst_on_issue: got wr=%0b cs=%0b rw=%0d data=%04h want 0 0 0 0000", t_wr, t_cs, rw_mode, t_data); end
        step();
        checks++; if (t_wr !== 1'b0 || rw_mode !== 2'b00) begin errors++; $display("FAIL rst_on_issue_after: got wr=%0b rw=%0d want 0 0", t_wr, rw_mode); end
        $display("reset during accept of a0=1 data=10 -> t_wr=%0b rw=%0d", t_wr, rw_mode);
    endtask

    initial begin
        test_reset();
        test_no_mode_err();
        test_pair();
        test_lsb_msb_only();
        test_held_strobe();
        test_abort_pair();
        test_cs_edge();
        test_reset_mid();
        test_reset_on_issue();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
